// File: rtl/demux_1to4_reg.sv
// Registered 1-to-4 demultiplexer with per-lane valid/ready handshake.
// Optional round-robin distribution is enabled with macro DEMUX_RR_EN.
module demux_1to4_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       sel,
`ifdef DEMUX_RR_EN
  input  logic             rr_mode,
`endif
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic             a_valid,
  output logic             b_valid,
  output logic             c_valid,
  output logic             d_valid,
  input  logic             a_ready,
  input  logic             b_ready,
  input  logic             c_ready,
  input  logic             d_ready,
  output logic [7:0]       xfer_cnt,
  output logic [1:0]       last_lane
);

  logic [WIDTH-1:0] lane_q [4];
  logic [3:0]       vld_q;
  logic [3:0]       rdy;
  logic [3:0]       load;
  logic [1:0]       tgt;
  logic             accept;

  assign rdy = {d_ready, c_ready, b_ready, a_ready};

`ifdef DEMUX_RR_EN
  logic [1:0] rr_ptr;

  always_comb begin
    tgt = sel;
    if (rr_mode) tgt = rr_ptr;
  end

  // Pointer only moves on an accepted word, so it waits on a full lane.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= 2'd0;
    end else if (accept && rr_mode) begin
      rr_ptr <= rr_ptr + 2'd1;
    end
  end
`else
  always_comb begin
    tgt = sel;
  end
`endif

  // A lane can take a new word if it is empty or emptying on this edge.
  assign in_ready = !vld_q[tgt] || rdy[tgt];
  assign accept   = in_valid && in_ready;

  always_comb begin
    load = 4'b0000;
    if (accept) load[tgt] = 1'b1;
  end

  for (genvar i = 0; i < 4; i++) begin : g_lane
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        lane_q[i] <= '0;
        vld_q[i]  <= 1'b0;
      end else if (load[i]) begin
        lane_q[i] <= in;
        vld_q[i]  <= 1'b1;
      end else if (vld_q[i] && rdy[i]) begin
        vld_q[i]  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt  <= 8'd0;
      last_lane <= 2'd0;
    end else if (accept) begin
      xfer_cnt  <= xfer_cnt + 8'd1;
      last_lane <= tgt;
    end
  end

  assign a       = lane_q[0];
  assign b       = lane_q[1];
  assign c       = lane_q[2];
  assign d       = lane_q[3];
  assign a_valid = vld_q[0];
  assign b_valid = vld_q[1];
  assign c_valid = vld_q[2];
  assign d_valid = vld_q[3];

endmodule

// File: tb/tb_demux_1to4_reg.sv
// Directed bench for demux_1to4_reg; round-robin steps run when DEMUX_RR_EN is defined.
module tb_demux_1to4_reg;

  logic       clk;
  logic       rst_n;
  logic [3:0] in;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] sel;
  logic [3:0] a, b, c, d;
  logic       a_valid, b_valid, c_valid, d_valid;
  logic       a_ready, b_ready, c_ready, d_ready;
  logic [7:0] xfer_cnt;
  logic [1:0] last_lane;
`ifdef DEMUX_RR_EN
  logic       rr_mode;
`endif

  int total = 0;
  int bad   = 0;

  demux_1to4_reg #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in(in), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel),
`ifdef DEMUX_RR_EN
    .rr_mode(rr_mode),
`endif
    .a(a), .b(b), .c(c), .d(d),
    .a_valid(a_valid), .b_valid(b_valid), .c_valid(c_valid), .d_valid(d_valid),
    .a_ready(a_ready), .b_ready(b_ready), .c_ready(c_ready), .d_ready(d_ready),
    .xfer_cnt(xfer_cnt), .last_lane(last_lane)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_clear(input string tag);
    chk({tag, "_a"}, {28'd0, a}, 32'd0);
    chk({tag, "_b"}, {28'd0, b}, 32'd0);
    chk({tag, "_c"}, {28'd0, c}, 32'd0);
    chk({tag, "_d"}, {28'd0, d}, 32'd0);
    chk({tag, "_vld"}, {28'd0, a_valid, b_valid, c_valid, d_valid}, 32'd0);
    chk({tag, "_cnt"}, {24'd0, xfer_cnt}, 32'd0);
    chk({tag, "_last"}, {30'd0, last_lane}, 32'd0);
    chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; in = '0; in_valid = 1'b0; sel = 2'd0;
    a_ready = 1'b0; b_ready = 1'b0; c_ready = 1'b0; d_ready = 1'b0;
`ifdef DEMUX_RR_EN
    rr_mode = 1'b0;
`endif
    #1;
    chk_all_clear("reset");
    tick(); tick();
    rst_n = 1'b1;

    // Single word into lane c, consumer stalled
    sel = 2'd2; in = 4'hA; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("c_load", {28'd0, c}, 32'hA);
    chk("c_valid", {31'd0, c_valid}, 32'd1);
    chk("cnt1", {24'd0, xfer_cnt}, 32'd1);
    chk("last2", {30'd0, last_lane}, 32'd2);

    // Full target stalls input although other lanes are empty
    sel = 2'd2; in = 4'h7; in_valid = 1'b1;
    #1;
    chk("full_rdy0", {31'd0, in_ready}, 32'd0);
    tick();
    chk("c_hold", {28'd0, c}, 32'hA);
    chk("cnt_hold", {24'd0, xfer_cnt}, 32'd1);
    sel = 2'd0;
    #1;
    chk("a_rdy1", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("a_load", {28'd0, a}, 32'h7);
    chk("a_valid", {31'd0, a_valid}, 32'd1);
    chk("cnt2", {24'd0, xfer_cnt}, 32'd2);
    chk("last0", {30'd0, last_lane}, 32'd0);

    // Drain a; data stays after valid drops
    a_ready = 1'b1;
    tick();
    a_ready = 1'b0;
    chk("a_drained", {31'd0, a_valid}, 32'd0);
    chk("a_keep", {28'd0, a}, 32'h7);

    // sel change without in_valid does nothing
    sel = 2'd1;
    tick();
    chk("idle_bvld", {31'd0, b_valid}, 32'd0);
    chk("idle_cnt", {24'd0, xfer_cnt}, 32'd2);
    chk("idle_last", {30'd0, last_lane}, 32'd0);

    // Same-edge drain and reload on b
    in = 4'h3; in_valid = 1'b1;
    tick();
    chk("b_first", {28'd0, b}, 32'h3);
    b_ready = 1'b1; in = 4'h5;
    #1;
    chk("b_rdy_drain", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("b_reload", {28'd0, b}, 32'h5);
    chk("b_vld_stay", {31'd0, b_valid}, 32'd1);
    chk("cnt4", {24'd0, xfer_cnt}, 32'd4);
    chk("last1", {30'd0, last_lane}, 32'd1);
    tick();
    b_ready = 1'b0;
    chk("b_drained", {31'd0, b_valid}, 32'd0);

    // c drains while d loads on the same edge
    c_ready = 1'b1; sel = 2'd3; in = 4'h9; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; c_ready = 1'b0;
    chk("c_drain", {31'd0, c_valid}, 32'd0);
    chk("d_load", {28'd0, d}, 32'h9);
    chk("d_valid", {31'd0, d_valid}, 32'd1);
    chk("cnt5", {24'd0, xfer_cnt}, 32'd5);
    chk("last3", {30'd0, last_lane}, 32'd3);

    // Fill all lanes then reset between edges
    in_valid = 1'b1;
    sel = 2'd0; in = 4'h1; tick();
    sel = 2'd1; in = 4'h2; tick();
    sel = 2'd2; in = 4'h4; tick();
    in_valid = 1'b0;
    chk("all_vld", {28'd0, a_valid, b_valid, c_valid, d_valid}, 32'hF);
    chk("cnt8", {24'd0, xfer_cnt}, 32'd8);
    rst_n = 1'b0;
    #1;
    chk_all_clear("midrst");
    #1;
    rst_n = 1'b1;

    // First word after reset accepted on the first edge
    sel = 2'd1; in = 4'h6; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("post_rst_b", {28'd0, b}, 32'h6);
    chk("post_rst_vld", {28'd0, a_valid, b_valid, c_valid, d_valid}, 32'h4);
    chk("post_rst_cnt", {24'd0, xfer_cnt}, 32'd1);

    // 256 transfers wrap the counter
    rst_n = 1'b0; #1; rst_n = 1'b1;
    a_ready = 1'b1; b_ready = 1'b1; c_ready = 1'b1; d_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      sel = i[1:0]; in = i[3:0]; in_valid = 1'b1;
      tick();
      if (i == 254) chk("cnt255", {24'd0, xfer_cnt}, 32'd255);
    end
    in_valid = 1'b0;
    chk("cnt_wrap", {24'd0, xfer_cnt}, 32'd0);
    chk("last_final", {30'd0, last_lane}, 32'd3);
    chk("d_final", {28'd0, d}, 32'hF);

`ifdef DEMUX_RR_EN
    // Round-robin: 1..5 land on a,b,c,d,a regardless of sel
    rst_n = 1'b0; #1; rst_n = 1'b1;
    rr_mode = 1'b1; sel = 2'd2; in_valid = 1'b1;
    in = 4'd1; tick(); chk("rr_a1", {28'd0, a}, 32'd1); chk("rr_l0", {30'd0, last_lane}, 32'd0);
    in = 4'd2; tick(); chk("rr_b2", {28'd0, b}, 32'd2); chk("rr_l1", {30'd0, last_lane}, 32'd1);
    in = 4'd3; tick(); chk("rr_c3", {28'd0, c}, 32'd3); chk("rr_l2", {30'd0, last_lane}, 32'd2);
    in = 4'd4; tick(); chk("rr_d4", {28'd0, d}, 32'd4); chk("rr_l3", {30'd0, last_lane}, 32'd3);
    in = 4'd5; tick(); chk("rr_a5", {28'd0, a}, 32'd5); chk("rr_l0b", {30'd0, last_lane}, 32'd0);
    // Fill d via sel with pointer held, then advance pointer to d
    d_ready = 1'b0; rr_mode = 1'b0; sel = 2'd3; in = 4'd8; tick();
    chk("rr_d8", {28'd0, d}, 32'd8);
    rr_mode = 1'b1;
    in = 4'd6; tick(); chk("rr_b6", {28'd0, b}, 32'd6);
    in = 4'd7; tick(); chk("rr_c7", {28'd0, c}, 32'd7);
    in = 4'd9;
    #1;
    chk("rr_stall_rdy", {31'd0, in_ready}, 32'd0);
    tick();
    chk("rr_stall_d", {28'd0, d}, 32'd8);
    chk("rr_stall_cnt", {24'd0, xfer_cnt}, 32'd8);
    d_ready = 1'b1;
    #1;
    chk("rr_resume_rdy", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("rr_d9", {28'd0, d}, 32'd9);
    chk("rr_cnt9", {24'd0, xfer_cnt}, 32'd9);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux_1to4_reg.md
DEMUX_1TO4_REG -- requirements
Module: demux_1to4_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the data width of the input and of each output lane.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in, input, WIDTH bits: the data word to be routed.
REQ-005 The block SHALL have port in_valid, input, 1 bit: in holds a valid word.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts in this cycle.
REQ-007 The block SHALL have port sel, input, 2 bits: destination lane, where 0=a, 1=b, 2=c, 3=d.
REQ-008 The block SHALL have ports a, b, c and d, outputs, WIDTH bits each: the lane data registers.
REQ-009 The block SHALL have ports a_valid, b_valid, c_valid and d_valid, outputs, 1 bit each: the lane holds an undelivered word.
REQ-010 The block SHALL have ports a_ready, b_ready, c_ready and d_ready, inputs, 1 bit each: the lane consumer takes the word.
REQ-011 The block SHALL have port xfer_cnt, output, 8 bits: count of accepted input transfers.
REQ-012 The block SHALL have port last_lane, output, 2 bits: destination lane of the most recent accepted transfer.

Function
REQ-013 The target lane SHALL be sel, unless it is overridden per REQ-029.
REQ-014 in_ready SHALL be combinational and equal to (!T_valid | T_ready), where T is the target lane.
- in_ready SHALL NOT depend on in_valid.
REQ-015 An input transfer SHALL occur on a clock edge where in_valid & in_ready; it SHALL load in into the target lane register and set T_valid.
- Latency from accept to T_valid is 1 cycle.
REQ-016 A lane transfer SHALL occur on an edge where X_valid & X_ready.
- Without a same-edge load, it SHALL clear X_valid.
- With a same-edge load, X_valid SHALL stay 1 and X SHALL take the new word.
REQ-017 While X_valid=1 and X_ready=0, X SHALL hold its value unchanged.
REQ-018 Non-target lanes SHALL be unaffected by in, in_valid and sel, and SHALL drain independently and concurrently.
REQ-019 Changing sel while in_valid=0 SHALL have no effect on any register.
REQ-020 A full target lane that is not draining SHALL force in_ready=0, even if other lanes are empty.
- No word SHALL be dropped or duplicated.
REQ-021 xfer_cnt SHALL increment by 1 per input transfer and wrap from 255 to 0.
REQ-022 last_lane SHALL update to the target lane on each input transfer and hold otherwise.
REQ-023 Lane data registers SHALL keep their last value after X_valid clears.

Reset
REQ-024 rst_n=0 SHALL immediately, without waiting for clk, clear the following to 0:
- a, b, c, d
- all *_valid
- xfer_cnt, last_lane
- the round-robin pointer
REQ-025 Reset asserted mid-operation SHALL discard all held words; no lane transfer SHALL be reported after release.
REQ-026 The first input transfer after reset SHALL be accepted on the first rising edge following rst_n deassertion.
REQ-027 in_ready SHALL be 1 during reset, since all lanes are empty.

Configuration
REQ-028 Macro DEMUX_RR_EN SHALL control round-robin distribution.
REQ-029 With DEMUX_RR_EN defined:
- The block SHALL add port rr_mode, input, 1 bit.
- When rr_mode=1, the target SHALL be a 2-bit pointer rr_ptr and sel SHALL be ignored.
- rr_ptr SHALL advance by 1, modulo 4, only on an input transfer; it SHALL stall at a full lane rather than skip it.
- When rr_mode=0, behaviour SHALL be as with sel, and rr_ptr SHALL hold.
REQ-030 Without DEMUX_RR_EN, rr_mode and rr_ptr SHALL NOT exist and the target SHALL always be sel.

Verification
REQ-031 The bench SHALL cover this scenario: reset, then sel=2, in=4'hA, in_valid=1 for one cycle, c_ready=0 -> next cycle c=4'hA, c_valid=1, xfer_cnt=1, last_lane=2.
REQ-032 The bench SHALL cover this scenario: c full with c_ready=0, sel=2, in_valid=1 -> in_ready=0 and c stays 4'hA; then sel=0 -> in_ready=1 and a loads in.
REQ-033 The bench SHALL cover this scenario: b_valid=1, b_ready=1, sel=1, in=4'h5, in_valid=1 on the same edge -> b=4'h5, b_valid stays 1, no gap.
REQ-034 The bench SHALL cover this scenario: 256 accepted transfers from reset -> xfer_cnt=0 and last_lane equals the final sel.
REQ-035 The bench SHALL cover this scenario: rst_n pulsed low between edges while all lanes are valid -> all outputs read 0 immediately, and in_ready=1.
REQ-036 The bench SHALL cover this scenario, with DEMUX_RR_EN defined: rr_mode=1, all *_ready=1, 5 words 1..5 -> they land on lanes a,b,c,d,a; with d_ready=0 and d full, rr_ptr=3 stalls with in_ready=0.
